// File: rtl/alu_exec.sv
// Execute-stage ALU with a registered result behind a valid/ready handshake.
// Define ALU_FAST_SHIFT_EN for single-cycle barrel shifts; the default build uses a serial 1-bit/cycle shifter.
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SW = $clog2(XLEN);

  localparam logic [3:0] SEL_SUB  = 4'd1;
  localparam logic [3:0] SEL_XOR  = 4'd2;
  localparam logic [3:0] SEL_OR   = 4'd3;
  localparam logic [3:0] SEL_AND  = 4'd4;
  localparam logic [3:0] SEL_SLL  = 4'd5;
  localparam logic [3:0] SEL_SRL  = 4'd6;
  localparam logic [3:0] SEL_SRA  = 4'd7;
  localparam logic [3:0] SEL_SLT  = 4'd8;
  localparam logic [3:0] SEL_SLTU = 4'd9;

  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            out_valid_q, out_valid_d;
  logic            accept;

  // Single-cycle result; in the serial build shifts only reach here with shamt==0 (identity).
  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] sel,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [XLEN-1:0]        r;
`ifdef ALU_FAST_SHIFT_EN
    logic [SW-1:0]          sh;
    sh = b[SW-1:0];
`endif
    sa = a;
    sb = b;
    case (sel)
      SEL_SUB:  r = a - b;
      SEL_XOR:  r = a ^ b;
      SEL_OR:   r = a | b;
      SEL_AND:  r = a & b;
`ifdef ALU_FAST_SHIFT_EN
      SEL_SLL:  r = a << sh;
      SEL_SRL:  r = a >> sh;
      SEL_SRA:  r = $unsigned(sa >>> sh);
`else
      SEL_SLL:  r = a;
      SEL_SRL:  r = a;
      SEL_SRA:  r = a;
`endif
      SEL_SLT:  r = XLEN'(sa < sb);
      SEL_SLTU: r = XLEN'(a < b);
      default:  r = a + b;
    endcase
    return r;
  endfunction

  assign accept    = in_valid && in_ready;
  assign result    = result_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

`ifdef ALU_FAST_SHIFT_EN

  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept) begin
      result_d    = alu_f(alu_sel, op_a, op_b);
      zero_d      = (result_d == '0);
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

`else

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] shreg_q, shreg_d;
  logic [1:0]      kind_q, kind_d;
  logic [SW-1:0]   shamt;
  logic            is_shift;

  // kind encodes alu_sel[1:0]: 01 SLL, 10 SRL, 11 SRA
  function automatic logic [XLEN-1:0] shift1(input logic [1:0] kind,
                                             input logic [XLEN-1:0] v);
    case (kind)
      2'b01:   return {v[XLEN-2:0], 1'b0};
      2'b10:   return {1'b0, v[XLEN-1:1]};
      default: return {v[XLEN-1], v[XLEN-1:1]};
    endcase
  endfunction

  assign shamt    = op_b[SW-1:0];
  assign is_shift = (alu_sel == SEL_SLL) || (alu_sel == SEL_SRL) || (alu_sel == SEL_SRA);
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    kind_d      = kind_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            shreg_d = op_a;
            cnt_d   = shamt;
            kind_d  = alu_sel[1:0];
            state_d = SHIFT;
          end else begin
            result_d    = alu_f(alu_sel, op_a, op_b);
            zero_d      = (result_d == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        shreg_d = shift1(kind_q, shreg_q);
        cnt_d   = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          result_d    = shreg_d;
          zero_d      = (shreg_d == '0);
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      kind_q      <= 2'b00;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      kind_q      <= kind_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

`endif

endmodule

// File: tb/tb_alu_exec.sv
// Directed table-driven bench for alu_exec plus hand-written backpressure and reset-mid-shift sequences.
module tb_alu_exec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_exec #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_sel   (alu_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        z;
    int          slow;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents one op, waits for accept, scrambles inputs, then waits for out_valid.
  task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat,
                        output int rdy_low);
    int n;
    in_valid = 1'b1;
    alu_sel  = sel;
    op_a     = a;
    op_b     = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_sel  = 4'd3;
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'h0000_0013;
    lat      = 1;
    rdy_low  = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) rdy_low++;
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    res = result;
    z   = zero;
  endtask

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat;
    int          rdy_low;
    int          exp_low;

    //          sel     a              b              exp            z     slow
    vecs[0]  = '{4'd0,  32'd5,         32'd7,         32'd12,        1'b0, 0};
    vecs[1]  = '{4'd1,  32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 0};
    vecs[2]  = '{4'd8,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 0};
    vecs[3]  = '{4'd9,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 0};
    vecs[4]  = '{4'd2,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0,         1'b1, 0};
    vecs[5]  = '{4'd3,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 0};
    vecs[6]  = '{4'd4,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 0};
    vecs[7]  = '{4'd7,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 4};
    vecs[8]  = '{4'd6,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 4};
    vecs[9]  = '{4'd5,  32'd1,         32'd31,        32'h8000_0000, 1'b0, 31};
    vecs[10] = '{4'd5,  32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 0};
    vecs[11] = '{4'd12, 32'd3,         32'd4,         32'd7,         1'b0, 0};
    vecs[12] = '{4'd8,  32'd1,         32'hFFFF_FFFF, 32'd0,         1'b1, 0};
    vecs[13] = '{4'd9,  32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0, 0};
    vecs[14] = '{4'd7,  32'h7000_0000, 32'h0000_0024, 32'h0700_0000, 1'b0, 4};
    vecs[15] = '{4'd0,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 0};
    vecs[16] = '{4'd6,  32'h0000_0001, 32'd1,         32'd0,         1'b1, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_sel   = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    result,             32'd0);
    chk("rst_zero",      {31'd0, zero},      32'd1);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, res, z, lat, rdy_low);
`ifdef ALU_FAST_SHIFT_EN
      exp_low = 0;
`else
      exp_low = vecs[i].slow;
`endif
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      chk($sformatf("v%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].z});
      chk($sformatf("v%0d_ready_low", i), rdy_low, exp_low);
      if (exp_low == 0) chk($sformatf("v%0d_latency", i), lat, 1);
    end

    // Backpressure: hold result while the consumer stalls, then pop+push in one cycle.
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(4'd0, 32'd10, 32'd20, res, z, lat, rdy_low);
    chk("bp_first", res, 32'd30);
    in_valid = 1'b1;
    alu_sel  = 4'd0;
    op_a     = 32'd1;
    op_b     = 32'd2;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_result_%0d", k), result, 32'd30);
      chk($sformatf("bp_hold_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_in_ready_%0d", k), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_release", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_b2b_valid",  {31'd0, out_valid}, 32'd1);
    chk("bp_b2b_result", result, 32'd3);
    @(posedge clk); #1;
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // Reset two cycles into SRA shamt=10: the op must vanish.
    in_valid = 1'b1;
    alu_sel  = 4'd7;
    op_a     = 32'h8000_0000;
    op_b     = 32'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_zero",   {31'd0, zero}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      chk($sformatf("no_stale_%0d", k), {31'd0, out_valid}, 32'd0);
    end
    chk("post_rst_result", result, 32'd0);

    run_op(4'd0, 32'd100, 32'd23, res, z, lat, rdy_low);
    chk("post_rst_add", res, 32'd123);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
